// File: rtl/spi_xfer_ctrl.sv
// -----------------------------------------------------------------------------
// spi_xfer_ctrl
//
// Sequencing controller for one SPI master word transfer (1..32 bits).
// A one-cycle start pulse latches the transfer configuration. The controller
// then walks SETUP -> SHIFT -> HOLD -> DONE while it drives chip-select, SCLK
// and MOSI, captures MISO and reports completion.
//
// Every state slot (SETUP, each SCLK half-period in SHIFT, HOLD) lasts
// H = baud_div + 1 clk cycles. SCLK toggles on the last cycle of each SHIFT
// slot, and MISO is sampled on that same clk edge.
//
// Ports
//   clk        in   system clock, rising edge
//   reset      in   synchronous active-low reset
//   start      in   one-cycle transfer request
//   tx_data    in   [DATA_W] word to send, right-aligned
//   word_size  in   [5]  bits per word minus 1
//   baud_div   in   [DIV_W] SCLK half-period in clk cycles minus 1
//   cpol       in   SCLK idle level
//   cpha       in   0: sample on leading edge, 1: sample on trailing edge
//   cs_sel     in   [2]  slave index
//   cs_auto    in   1: CS framed by controller, 0: CS follows cs_force
//   cs_force   in   manual CS level (1 = asserted)
//   miso       in   serial data in
//   sclk       out  serial clock
//   mosi       out  serial data out
//   cs_n       out  [4]  active-low chip selects
//   rx_data    out  [DATA_W] received word, bits above word_size are 0
//   busy       out  high in SETUP, SHIFT and HOLD
//   done       out  one-cycle completion pulse
// -----------------------------------------------------------------------------
module spi_xfer_ctrl #(
    parameter int DATA_W = 32,
    parameter int DIV_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] tx_data,
    input  logic [4:0]        word_size,
    input  logic [DIV_W-1:0]  baud_div,
    input  logic              cpol,
    input  logic              cpha,
    input  logic [1:0]        cs_sel,
    input  logic              cs_auto,
    input  logic              cs_force,
    input  logic              miso,
    output logic              sclk,
    output logic              mosi,
    output logic [3:0]        cs_n,
    output logic [DATA_W-1:0] rx_data,
    output logic              busy,
    output logic              done
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_SHIFT = 3'd2,
        ST_HOLD  = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam logic [DIV_W-1:0] CNT_ONE = {{(DIV_W-1){1'b0}}, 1'b1};

    // Drive value for the four chip-select lines: one slave low when active.
    function automatic logic [3:0] cs_decode(input logic [1:0] sel, input logic active);
        logic [3:0] onehot;
        onehot = 4'b0001 << sel;
        if (active) begin
            cs_decode = ~onehot;
        end else begin
            cs_decode = 4'hF;
        end
    endfunction

    // Registered state and latched configuration
    state_t            state_r;
    logic [DIV_W-1:0]  cnt_r;
    logic [5:0]        edge_r;
    logic [DATA_W-1:0] tx_sh_r;
    logic [DATA_W-1:0] rx_sh_r;
    logic [4:0]        ws_r;
    logic [DIV_W-1:0]  div_r;
    logic              cpol_r;
    logic              cpha_r;
    logic [1:0]        sel_r;
    logic              auto_r;

    // Combinational decode
    state_t            state_next_s;
    logic              accept_s;
    logic              slot_end_s;
    logic              sclk_edge_s;
    logic              leading_s;
    logic              last_edge_s;
    logic              sample_s;
    logic              present_s;
    logic [DIV_W-1:0]  cnt_next_s;
    logic [5:0]        edge_next_s;
    logic [1:0]        cfg_sel_s;
    logic              cfg_auto_s;
    logic [3:0]        cs_n_next_s;
    logic [DATA_W-1:0] tx_shifted_s;
    logic [DATA_W-1:0] rx_mask_s;

    // Slot timing and edge classification derived from the latched configuration.
    always_comb begin
        slot_end_s   = (cnt_r == div_r);
        sclk_edge_s  = (state_r == ST_SHIFT) && slot_end_s;
        // edge_r counts completed edges, so an even count means the next edge is odd (leading)
        leading_s    = ~edge_r[0];
        last_edge_s  = (edge_r == {ws_r, 1'b1});
        tx_shifted_s = tx_sh_r << 1;
        rx_mask_s    = ~({DATA_W{1'b1}} << ({1'b0, ws_r} + 6'd1));
        if (cpha_r) begin
            sample_s  = sclk_edge_s && ~leading_s;
            present_s = sclk_edge_s && leading_s;
        end else begin
            sample_s  = sclk_edge_s && leading_s;
            // the final trailing edge has no further bit to present
            present_s = sclk_edge_s && ~leading_s && ~last_edge_s;
        end
    end

    // Next-state logic; start is honoured only in IDLE and in the DONE cycle.
    always_comb begin
        state_next_s = state_r;
        accept_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_next_s = ST_SETUP;
                    accept_s     = 1'b1;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_SETUP: begin
                if (slot_end_s) begin
                    state_next_s = ST_SHIFT;
                end else begin
                    state_next_s = ST_SETUP;
                end
            end
            ST_SHIFT: begin
                if (slot_end_s && last_edge_s) begin
                    state_next_s = ST_HOLD;
                end else begin
                    state_next_s = ST_SHIFT;
                end
            end
            ST_HOLD: begin
                if (slot_end_s) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_HOLD;
                end
            end
            ST_DONE: begin
                if (start) begin
                    state_next_s = ST_SETUP;
                    accept_s     = 1'b1;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Slot cycle counter and SCLK edge counter updates.
    always_comb begin
        cnt_next_s  = '0;
        edge_next_s = edge_r;
        if (((state_r == ST_SETUP) || (state_r == ST_SHIFT) || (state_r == ST_HOLD)) && !slot_end_s) begin
            cnt_next_s = cnt_r + CNT_ONE;
        end else begin
            cnt_next_s = '0;
        end
        if (accept_s) begin
            edge_next_s = 6'd0;
        end else if (sclk_edge_s) begin
            edge_next_s = edge_r + 6'd1;
        end else begin
            edge_next_s = edge_r;
        end
    end

    // Chip-select value for the coming cycle. A freshly accepted start uses the
    // live configuration; otherwise the latched one governs the transfer and
    // IDLE follows the live manual controls.
    always_comb begin
        cs_n_next_s = 4'hF;
        if (accept_s) begin
            cfg_sel_s  = cs_sel;
            cfg_auto_s = cs_auto;
        end else begin
            cfg_sel_s  = sel_r;
            cfg_auto_s = auto_r;
        end
        case (state_next_s)
            ST_SETUP, ST_SHIFT, ST_HOLD: begin
                if (cfg_auto_s) begin
                    cs_n_next_s = cs_decode(cfg_sel_s, 1'b1);
                end else begin
                    cs_n_next_s = cs_decode(cfg_sel_s, cs_force);
                end
            end
            ST_DONE: begin
                if (cfg_auto_s) begin
                    cs_n_next_s = 4'hF;
                end else begin
                    cs_n_next_s = cs_decode(cfg_sel_s, cs_force);
                end
            end
            ST_IDLE: begin
                if (cs_auto) begin
                    cs_n_next_s = 4'hF;
                end else begin
                    cs_n_next_s = cs_decode(cs_sel, cs_force);
                end
            end
            default: begin
                cs_n_next_s = 4'hF;
            end
        endcase
    end

    // State register, counters and status outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r <= ST_IDLE;
            cnt_r   <= '0;
            edge_r  <= 6'd0;
            busy    <= 1'b0;
            done    <= 1'b0;
            cs_n    <= 4'hF;
        end else begin
            state_r <= state_next_s;
            cnt_r   <= cnt_next_s;
            edge_r  <= edge_next_s;
            busy    <= (state_next_s == ST_SETUP) || (state_next_s == ST_SHIFT) ||
                       (state_next_s == ST_HOLD);
            done    <= (state_next_s == ST_DONE);
            cs_n    <= cs_n_next_s;
        end
    end

    // Configuration latch, captured only when a start is accepted.
    always_ff @(posedge clk) begin
        if (!reset) begin
            ws_r   <= 5'd0;
            div_r  <= '0;
            cpol_r <= 1'b0;
            cpha_r <= 1'b0;
            sel_r  <= 2'd0;
            auto_r <= 1'b0;
        end else if (accept_s) begin
            ws_r   <= word_size;
            div_r  <= baud_div;
            cpol_r <= cpol;
            cpha_r <= cpha;
            sel_r  <= cs_sel;
            auto_r <= cs_auto;
        end
    end

    // Transmit shift register and MOSI. The MSB of the word sits at bit ws_r;
    // each presented bit shifts the register left so the next one moves there.
    always_ff @(posedge clk) begin
        if (!reset) begin
            tx_sh_r <= '0;
            mosi    <= 1'b0;
        end else if (accept_s) begin
            tx_sh_r <= tx_data;
            // cpha=0 needs the first bit on the wire before the first leading edge
            if (!cpha) begin
                mosi <= tx_data[word_size];
            end
        end else if (present_s) begin
            tx_sh_r <= tx_shifted_s;
            if (cpha_r) begin
                mosi <= tx_sh_r[ws_r];
            end else begin
                mosi <= tx_shifted_s[ws_r];
            end
        end
    end

    // Receive shift register and the masked result published on entry to DONE.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rx_sh_r <= '0;
            rx_data <= '0;
        end else begin
            if (accept_s) begin
                rx_sh_r <= '0;
            end else if (sample_s) begin
                rx_sh_r <= {rx_sh_r[DATA_W-2:0], miso};
            end
            if (state_next_s == ST_DONE) begin
                rx_data <= rx_sh_r & rx_mask_s;
            end
        end
    end

    // SCLK: tracks cpol while idle, toggles on SHIFT slot ends, parks at the
    // latched cpol elsewhere.
    always_ff @(posedge clk) begin
        if (!reset) begin
            sclk <= 1'b0;
        end else if (accept_s || (state_r == ST_IDLE)) begin
            sclk <= cpol;
        end else if (state_r == ST_SHIFT) begin
            if (sclk_edge_s) begin
                sclk <= ~sclk;
            end
        end else begin
            sclk <= cpol_r;
        end
    end

endmodule

// File: tb/tb_spi_xfer_ctrl.sv
module tb_spi_xfer_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] tx_data;
    logic [4:0]  word_size;
    logic [7:0]  baud_div;
    logic        cpol;
    logic        cpha;
    logic [1:0]  cs_sel;
    logic        cs_auto;
    logic        cs_force;
    logic        miso;
    logic        sclk;
    logic        mosi;
    logic [3:0]  cs_n;
    logic [31:0] rx_data;
    logic        busy;
    logic        done;

    logic        miso_drv;
    logic        loop_en;
    int          checks = 0;
    int          errors = 0;

    assign miso = loop_en ? mosi : miso_drv;

    spi_xfer_ctrl #(.DATA_W(32), .DIV_W(8)) dut (
        .clk(clk), .reset(reset), .start(start), .tx_data(tx_data),
        .word_size(word_size), .baud_div(baud_div), .cpol(cpol), .cpha(cpha),
        .cs_sel(cs_sel), .cs_auto(cs_auto), .cs_force(cs_force), .miso(miso),
        .sclk(sclk), .mosi(mosi), .cs_n(cs_n), .rx_data(rx_data),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Runs one transfer against a slave model and checks it against the
    // expected totals: busy length (2N+2)H, 2N SCLK edges at (i+1)H, MSB-first
    // MOSI stream, received word, chip-select level. Returns in the DONE cycle.
    task automatic run_xfer(input string name, input logic [31:0] tx, input logic [4:0] ws,
                            input logic [7:0] div, input logic pol, input logic pha,
                            input logic [1:0] sel, input logic auto, input logic force_v,
                            input logic [31:0] sword, input logic loop, input int inject_t);
        int n, h, blen, t, toggles, sp, time_err, cs_err, busy_cnt, done_t;
        logic prev_sclk, leading, done_seen;
        logic [31:0] mask, mosi_bits, exp_rx;
        logic [3:0] exp_cs_act, exp_cs_done, onehot_n;
        n = int'(ws) + 1;
        h = int'(div) + 1;
        blen = (2 * n + 2) * h;
        mask = (n == 32) ? 32'hFFFF_FFFF : ((32'd1 << n) - 32'd1);
        exp_rx = (loop ? tx : sword) & mask;
        onehot_n = ~(4'b0001 << sel);
        exp_cs_act = (auto || force_v) ? onehot_n : 4'hF;
        exp_cs_done = auto ? 4'hF : exp_cs_act;

        tx_data = tx; word_size = ws; baud_div = div; cpol = pol; cpha = pha;
        cs_sel = sel; cs_auto = auto; cs_force = force_v; loop_en = loop;
        start = 1'b1;
        sp = n - 1;
        if (!pha) begin
            miso_drv = sword[sp];
            sp--;
        end
        prev_sclk = pol; t = 0; toggles = 0; time_err = 0; cs_err = 0;
        busy_cnt = 0; done_t = 0; done_seen = 1'b0; mosi_bits = 32'd0;
        while (!done_seen && t < 2000) begin
            @(negedge clk);
            t++;
            if (t == 1) begin
                start = 1'b0;
                checks++;
                if (busy !== 1'b1) begin
                    errors++;
                    $display("FAIL %s busy_first_cycle: got %b expected 1", name, busy);
                end
            end
            if (t == inject_t) begin
                start = 1'b1;
                tx_data = $urandom;
                word_size = 5'($urandom_range(0, 31));
                baud_div = 8'($urandom_range(0, 7));
                cpol = ~pol;
                cpha = ~pha;
                cs_sel = sel + 2'd1;
                cs_auto = 1'($urandom_range(0, 1));
            end else if (t == inject_t + 1) begin
                start = 1'b0;
            end
            if (busy === 1'b1) busy_cnt++;
            if (sclk !== prev_sclk) begin
                toggles++;
                if (t != (toggles + 1) * h + 1) time_err++;
                leading = ((toggles % 2) == 1);
                if (leading == !pha) mosi_bits = {mosi_bits[30:0], mosi};
                if (!loop && sp >= 0 && ((!pha && !leading) || (pha && leading))) begin
                    miso_drv = sword[sp];
                    sp--;
                end
                prev_sclk = sclk;
            end
            if (busy === 1'b1 && cs_n !== exp_cs_act) cs_err++;
            if (done === 1'b1) begin
                done_seen = 1'b1;
                done_t = t;
            end
        end
        checks++;
        if (!done_seen) begin
            errors++;
            $display("FAIL %s done_timeout: got no done in %0d cycles expected done at %0d", name, t, blen + 1);
        end else begin
            checks++;
            if (done_t != blen + 1) begin
                errors++;
                $display("FAIL %s done_time: got %0d expected %0d", name, done_t, blen + 1);
            end
            checks++;
            if (busy_cnt != blen) begin
                errors++;
                $display("FAIL %s busy_len: got %0d expected %0d", name, busy_cnt, blen);
            end
            checks++;
            if (toggles != 2 * n) begin
                errors++;
                $display("FAIL %s sclk_edges: got %0d expected %0d", name, toggles, 2 * n);
            end
            checks++;
            if (time_err != 0) begin
                errors++;
                $display("FAIL %s sclk_edge_timing: got %0d misplaced edges expected 0", name, time_err);
            end
            checks++;
            if (mosi_bits !== (tx & mask)) begin
                errors++;
                $display("FAIL %s mosi_stream: got %h expected %h", name, mosi_bits, tx & mask);
            end
            checks++;
            if (rx_data !== exp_rx) begin
                errors++;
                $display("FAIL %s rx_data: got %h expected %h", name, rx_data, exp_rx);
            end
            checks++;
            if (cs_err != 0) begin
                errors++;
                $display("FAIL %s cs_during_xfer: got %0d bad cycles expected 0 (cs_n=%b)", name, cs_err, exp_cs_act);
            end
            checks++;
            if (cs_n !== exp_cs_done || busy !== 1'b0 || sclk !== pol) begin
                errors++;
                $display("FAIL %s done_cycle_outputs: got cs_n=%b busy=%b sclk=%b expected cs_n=%b busy=0 sclk=%b",
                         name, cs_n, busy, sclk, exp_cs_done, pol);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; start = 1'b0; tx_data = 32'd0; word_size = 5'd0; baud_div = 8'd0;
        cpol = 1'b1; cpha = 1'b0; cs_sel = 2'd0; cs_auto = 1'b1; cs_force = 1'b0;
        miso_drv = 1'b0; loop_en = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (sclk !== 1'b0 || mosi !== 1'b0 || cs_n !== 4'hF || rx_data !== 32'd0 ||
            busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_values: got sclk=%b mosi=%b cs_n=%b rx=%h busy=%b done=%b expected 0 0 1111 0 0 0",
                     sclk, mosi, cs_n, rx_data, busy, done);
        end
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (sclk !== 1'b1) begin
            errors++;
            $display("FAIL idle_sclk_cpol1: got %b expected 1", sclk);
        end
        cpol = 1'b0;
        @(negedge clk);
        checks++;
        if (sclk !== 1'b0) begin
            errors++;
            $display("FAIL idle_sclk_cpol0: got %b expected 0", sclk);
        end
    endtask

    task automatic test_mode0();
        run_xfer("mode0_loop", 32'h0000_00A5, 5'd7, 8'd1, 1'b0, 1'b0, 2'd2, 1'b1, 1'b0,
                 32'd0, 1'b1, 0);
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL mode0_done_width: got done=%b busy=%b expected 0 0", done, busy);
        end
    endtask

    task automatic test_mode3();
        cpol = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (sclk !== 1'b1) begin
            errors++;
            $display("FAIL mode3_idle_sclk: got %b expected 1", sclk);
        end
        run_xfer("mode3", 32'hDEAD_BEEF, 5'd31, 8'd0, 1'b1, 1'b1, 2'd0, 1'b1, 1'b0,
                 32'h1234_5678, 1'b0, 0);
        repeat (2) @(negedge clk);
    endtask

    task automatic test_back_to_back();
        run_xfer("b2b_first", $urandom, 5'd5, 8'd1, 1'b0, 1'b0, 2'd1, 1'b1, 1'b0,
                 $urandom, 1'b0, 5);
        run_xfer("b2b_second", $urandom, 5'd6, 8'd0, 1'b1, 1'b0, 2'd3, 1'b1, 1'b0,
                 $urandom | 32'h1, 1'b0, 0);
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_idle_after: got done=%b busy=%b expected 0 0", done, busy);
        end
    endtask

    task automatic test_reset_mid();
        int stray;
        tx_data = $urandom; word_size = 5'd15; baud_div = 8'd1; cpol = 1'b1; cpha = 1'b0;
        cs_sel = 2'd3; cs_auto = 1'b1; loop_en = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (cs_n !== 4'hF || sclk !== 1'b0 || busy !== 1'b0 || rx_data !== 32'd0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_shift: got cs_n=%b sclk=%b busy=%b rx=%h done=%b expected 1111 0 0 0 0",
                     cs_n, sclk, busy, rx_data, done);
        end
        stray = 0;
        repeat (3) begin
            @(negedge clk);
            if (done !== 1'b0) stray++;
        end
        reset = 1'b1;
        repeat (40) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0) stray++;
        end
        checks++;
        if (stray != 0) begin
            errors++;
            $display("FAIL reset_abort_no_done: got %0d cycles with done/busy expected 0", stray);
        end
    endtask

    task automatic test_manual_cs();
        cs_auto = 1'b0; cs_sel = 2'd1; cs_force = 1'b0; cpol = 1'b0; loop_en = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (cs_n !== 4'hF) begin
            errors++;
            $display("FAIL manual_cs_off: got %b expected 1111", cs_n);
        end
        cs_force = 1'b1;
        #1;
        checks++;
        if (cs_n !== 4'hF) begin
            errors++;
            $display("FAIL manual_cs_latency: got %b expected 1111 before the clock edge", cs_n);
        end
        @(negedge clk);
        checks++;
        if (cs_n !== 4'hD) begin
            errors++;
            $display("FAIL manual_cs_on: got %b expected 1101", cs_n);
        end
        run_xfer("manual_xfer", $urandom, 5'd9, 8'd0, 1'b0, 1'b1, 2'd1, 1'b0, 1'b1,
                 $urandom, 1'b0, 0);
        @(negedge clk);
        checks++;
        if (cs_n !== 4'hD) begin
            errors++;
            $display("FAIL manual_cs_after_xfer: got %b expected 1101", cs_n);
        end
        cs_force = 1'b0;
        @(negedge clk);
        checks++;
        if (cs_n !== 4'hF) begin
            errors++;
            $display("FAIL manual_cs_release: got %b expected 1111", cs_n);
        end
    endtask

    task automatic test_single_bit();
        run_xfer("single_bit", 32'h0000_0001, 5'd0, 8'd3, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0,
                 32'h0000_0001, 1'b0, 0);
        repeat (2) @(negedge clk);
    endtask

    task automatic test_random();
        for (int i = 0; i < 12; i++) begin
            run_xfer($sformatf("random_%0d", i), $urandom, 5'($urandom_range(0, 31)),
                     8'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     $urandom, 1'($urandom_range(0, 1)), 0);
            repeat (2) @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_mode0();
        test_mode3();
        test_back_to_back();
        test_reset_mid();
        test_manual_cs();
        test_single_bit();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_xfer_ctrl.md
# spi_xfer_ctrl

Sequencing controller for the SPI master datapath. It accepts a one-cycle `start` pulse from the register-write edge detector and latches the transfer configuration. It then drives chip-select, the serial clock and MOSI for one word of 1–32 bits, captures MISO into `rx_data`, and reports completion with `busy` and a one-cycle `done` pulse. It sits between the bus register file and the SPI pins.

## Interface
- `DATA_W`, default 32: maximum word width; `tx_data` and `rx_data` width.
- `DIV_W`, default 8: width of `baud_div`.

Ports:
- `clk`  in  1  system clock; all logic on its rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `start`  in  1  one-cycle request pulse from the edge detector.
- `tx_data`  in  DATA_W  word to send, right-aligned.
- `word_size`  in  5  bits per word minus 1 (0 gives 1 bit, 31 gives 32 bits).
- `baud_div`  in  DIV_W  SCLK half-period in clk cycles, minus 1.
- `cpol`  in  1  SCLK idle level.
- `cpha`  in  1  0: sample on leading edge; 1: sample on trailing edge.
- `cs_sel`  in  2  slave to address.
- `cs_auto`  in  1  1: controller drives CS around the transfer; 0: CS follows `cs_force`.
- `cs_force`  in  1  manual CS level (1 = asserted); used only when `cs_auto`=0.
- `miso`  in  1  serial data in.
- `sclk`  out  1  serial clock.
- `mosi`  out  1  serial data out.
- `cs_n`  out  4  active-low chip selects.
- `rx_data`  out  DATA_W  received word, right-aligned; bits above `word_size` are 0.
- `busy`  out  1  transfer in progress.
- `done`  out  1  one-cycle completion pulse.

## Operation
- Reset (`reset`=0) values: `sclk`=0, `mosi`=0, `cs_n`=4'hF, `rx_data`=0, `busy`=0, `done`=0, state IDLE, counters cleared.
- Reset has priority over everything. Reset mid-transfer aborts immediately: no `done`, all CS deasserted, and `rx_data` cleared.
- States and transitions:
  - IDLE: `sclk` follows `cpol`, registered every cycle. A `start` latches `tx_data`, `word_size`, `baud_div`, `cpol`, `cpha`, `cs_sel` and `cs_auto`, then moves to SETUP. `start` while not IDLE is ignored; there is no queueing.
  - SETUP: lasts H = `baud_div`+1 cycles. CS is asserted if `cs_auto`=1. With `cpha`=0, `mosi` = bit `word_size` of the latched word from the first SETUP cycle.
  - SHIFT: 2N SCLK edges, where N = `word_size`+1, one edge every H cycles. `sclk` toggles on each edge; odd edges are leading, even edges are trailing.
    - `cpha`=0: sample `miso` on leading edges; present the next bit on trailing edges, except the last trailing edge.
    - `cpha`=1: present the next bit on leading edges, sample on trailing edges.
    - Bit order is MSB first.
  - HOLD: H cycles. `sclk` stays at `cpol`; CS remains asserted.
  - DONE: one cycle. `done`=1, `busy`=0, `rx_data` updated, CS deasserted (if `cs_auto`). Then return to IDLE.
- A `start` in the DONE cycle is accepted, allowing back-to-back transfers.
- `busy`=1 in SETUP, SHIFT and HOLD only.
- Chip select:
  - With `cs_auto`=1: `cs_n[cs_sel]`=0 and all other bits 1, from SETUP through HOLD.
  - With `cs_auto`=0: `cs_n[cs_sel]` = ~`cs_force`, registered with one cycle latency, in every state.
- Shift register and receive path:
  - Internal shift registers are DATA_W wide.
  - The receive path shifts left and inserts `miso` at bit 0.
  - `rx_data` is loaded with the received bits masked to N bits in the DONE cycle, and holds until the next DONE or reset.
- Configuration inputs changing mid-transfer have no effect, because all configuration is latched at `start`.

## Timing
- `start` sampled at rising edge k: `busy`=1 from cycle k+1; first SETUP cycle is k+1.
- `busy` stays high for (2N+2)·H cycles. `done` occurs at cycle k+1+(2N+2)·H.
- SCLK edge i (i = 1..2N) occurs at cycle k+1+(i+1)·H−1 relative to SETUP start, i.e. on the last cycle of each H-cycle slot.
- `miso` is sampled on the same clk edge that toggles `sclk`.
- Minimum `baud_div`=0 gives H=1: SCLK = clk/2 and a transfer of N+1 clk-periods' worth of SCLK cycles.
- All outputs are registered; there are no combinational input-to-output paths.

## Test plan
- Mode 0 (`cpol`=0, `cpha`=0), `baud_div`=1, `word_size`=7, `tx_data`=0xA5, `miso` looped to `mosi`, `cs_sel`=2, `cs_auto`=1 -> `busy` high for 36 cycles, exactly 16 `sclk` edges, `cs_n`=4'b1011 during the transfer, `done` one cycle, `rx_data`=0x000000A5.
- Mode 3 (`cpol`=1, `cpha`=1), `baud_div`=0, `word_size`=31, `tx_data`=0xDEADBEEF, slave model returns 0x12345678 -> `sclk` idles at 1, `busy` 66 cycles, `rx_data`=0x12345678, MOSI bit stream matches 0xDEADBEEF MSB first.
- `start` pulsed again 5 cycles into a transfer, and again in the DONE cycle -> first is ignored; second starts a new transfer with `busy`=1 on the next cycle.
- `reset` driven low during SHIFT -> the next cycle shows `cs_n`=4'hF, `sclk`=0, `busy`=0, `rx_data`=0, and no `done`.
- `cs_auto`=0, `cs_sel`=1, `cs_force` toggled 0→1→0 -> `cs_n` goes 4'hF→4'hD→4'hF with one cycle latency. A transfer started while forced runs without altering `cs_n`.
- `word_size`=0, `baud_div`=3, `tx_data`=0x1, `miso`=1 -> `busy` 16 cycles, 2 SCLK edges, `rx_data`=0x00000001.
